// File: rtl/mbed_instr_receiver_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
//   Shared definitions for the servo controller instruction path: frame width,
//   field positions inside an assembled instruction, default parity/timeout
//   settings and the receiver state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package servo_pkg;

  // Payload bits per instruction, transmitted MSB first.
  localparam int FRAME_W             = 11;
  // 1: an even-parity bit trails the payload.
  localparam int DEFAULT_PARITY_EN   = 1;
  // 100 ms at 50 MHz between confirm rises before a partial frame is dropped.
  localparam int DEFAULT_TIMEOUT_CYC = 5_000_000;

  // Field positions inside the assembled instruction.
  localparam int INSTR_MAINT_BIT = 9;
  localparam int INSTR_POS_MSB   = 7;
  localparam int INSTR_POS_LSB   = 0;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RECV     = 2'd1,
    ST_CHECK    = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/mbed_instr_receiver_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//   Brings an asynchronous pin into the clk domain through two flops and
//   flags its rising edge with a one-cycle pulse, using one extra delay flop.
// Ports
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   d_i     in   asynchronous input pin
//   sync_o  out  synchronised level (2 clk after the pin)
//   rise_o  out  1-cycle pulse in the cycle sync_o first reads 1
// -----------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~dly_q;

endmodule

// File: rtl/mbed_instr_receiver.sv
// -----------------------------------------------------------------------------
// mbed_instr_receiver
//   Assembles a serial instruction from the MBED (data bit + confirm strobe per
//   bit) into a FRAME_W-bit word, optionally checks even parity, and holds the
//   result stable for the servo state machine. Partial frames are discarded
//   after TIMEOUT_CYC idle cycles between confirm rises.
// Ports
//   clk          in   system clock (50 MHz)
//   reset        in   synchronous active-low reset
//   enable       in   1 = servo FSM wants an instruction
//   clear        in   synchronous clear of held/partial instruction
//   mbedCommand  in   serial data bit (asynchronous)
//   confirm      in   bit strobe (asynchronous), rising edge samples data
//   instr        out  assembled instruction, stable while instr_valid=1
//   instr_valid  out  instr holds a complete, parity-good frame
//   waiting      out  receiver is accepting bits
//   frame_err    out  1-cycle pulse on parity error or inter-bit timeout
// -----------------------------------------------------------------------------
module mbed_instr_receiver #(
  parameter int FRAME_W     = servo_pkg::FRAME_W,
  parameter int PARITY_EN   = servo_pkg::DEFAULT_PARITY_EN,
  parameter int TIMEOUT_CYC = servo_pkg::DEFAULT_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               mbedCommand,
  input  logic               confirm,
  output logic [FRAME_W-1:0] instr,
  output logic               instr_valid,
  output logic               waiting,
  output logic               frame_err
);

  import servo_pkg::*;

  localparam int N  = FRAME_W + PARITY_EN;
  localparam int CW = $clog2(N + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(N);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  logic cmd_s;
  logic cmd_rise_unused;
  logic conf_rise;

  state_e             state_q;
  logic [N-1:0]       shreg_q;
  logic [CW-1:0]      count_q;
  logic [TW-1:0]      timer_q;
  logic [FRAME_W-1:0] instr_q;
  logic               instr_valid_q;
  logic               waiting_q;
  logic               frame_err_q;

  // Both pins see identical synchroniser depth, so cmd_s is aligned with the
  // cycle in which conf_rise is asserted.
  sync_edge_detect u_sync_cmd (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (mbedCommand),
    .sync_o (cmd_s),
    .rise_o (cmd_rise_unused)
  );

  sync_edge_detect u_sync_conf (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (confirm),
    .sync_o (),
    .rise_o (conf_rise)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_DISABLED;
      shreg_q       <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      waiting_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (clear) begin
        // Clear wins over everything, including a rise in the same cycle.
        instr_q       <= '0;
        instr_valid_q <= 1'b0;
        count_q       <= '0;
        timer_q       <= '0;
        state_q       <= enable ? ST_RECV : ST_DISABLED;
        waiting_q     <= enable;
      end else begin
        unique case (state_q)
          ST_DISABLED: begin
            if (enable) begin
              state_q   <= ST_RECV;
              waiting_q <= 1'b1;
              count_q   <= '0;
              timer_q   <= '0;
            end
          end

          ST_RECV: begin
            if (!enable) begin
              state_q   <= ST_DISABLED;
              waiting_q <= 1'b0;
              count_q   <= '0;
              timer_q   <= '0;
            end else if (count_q == COUNT_FULL) begin
              state_q   <= ST_CHECK;
              waiting_q <= 1'b0;
            end else if (conf_rise) begin
              // A rise beats a coincident timeout.
              shreg_q <= {shreg_q[N-2:0], cmd_s};
              count_q <= count_q + 1'b1;
              timer_q <= '0;
            end else if (count_q != '0) begin
              if (timer_q == TIMER_LAST) begin
                frame_err_q <= 1'b1;
                count_q     <= '0;
                timer_q     <= '0;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
          end

          ST_CHECK: begin
            if ((PARITY_EN != 0) && (^shreg_q)) begin
              frame_err_q <= 1'b1;
              state_q     <= ST_RECV;
              waiting_q   <= 1'b1;
              count_q     <= '0;
              timer_q     <= '0;
            end else begin
              // First received bit sits at shreg_q[N-1] -> instr MSB.
              instr_q       <= shreg_q[N-1 -: FRAME_W];
              instr_valid_q <= 1'b1;
              state_q       <= ST_DONE;
            end
          end

          ST_DONE: begin
            if (!enable) begin
              state_q       <= ST_DISABLED;
              instr_valid_q <= 1'b0;
            end
          end

          default: begin
            state_q   <= ST_DISABLED;
            waiting_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign waiting     = waiting_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_mbed_instr_receiver.sv
`timescale 1ns/1ps
module tb_mbed_instr_receiver;

  localparam int FW   = 11;
  localparam int TO   = 1000;
  localparam int HALF = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          mbedCommand = 1'b0;
  logic          confirm = 1'b0;
  logic [FW-1:0] instr;
  logic          instr_valid;
  logic          waiting;
  logic          frame_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #10 clk = ~clk;

  mbed_instr_receiver #(
    .FRAME_W     (FW),
    .PARITY_EN   (1),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .mbedCommand (mbedCommand),
    .confirm     (confirm),
    .instr       (instr),
    .instr_valid (instr_valid),
    .waiting     (waiting),
    .frame_err   (frame_err)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    mbedCommand = b;
    confirm = 1'b1;
    repeat (HALF) @(negedge clk);
    confirm = 1'b0;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input logic p);
    for (int i = FW - 1; i >= 0; i--) send_bit(f[i]);
    send_bit(p);
    repeat (5) @(negedge clk);
    $display("frame sent %h parity %b -> instr=%h valid=%b", f, p, instr, instr_valid);
  endtask

  task automatic rearm();
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (instr !== 11'h000) $display("FAIL reset_instr: got %h expected 000", instr); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else pass_cnt++;
    total_cnt++; if (waiting !== 1'b0) $display("FAIL reset_waiting: got %b expected 0", waiting); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [FW-1:0] f;
    f = 11'h2A5;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = FW - 1; i >= 6; i--) send_bit(f[i]);
    total_cnt++; if (waiting !== 1'b1) $display("FAIL nominal_waiting_mid: got %b expected 1", waiting); else pass_cnt++;
    for (int i = 5; i >= 0; i--) send_bit(f[i]);
    // Final (parity) bit: measure latency from pin edge.
    @(negedge clk);
    mbedCommand = 1'b1;
    confirm = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL nominal_valid_at4: got %b expected 0", instr_valid); else pass_cnt++;
    total_cnt++; if (waiting !== 1'b0) $display("FAIL nominal_waiting_check: got %b expected 0", waiting); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL nominal_valid_at5: got %b expected 1", instr_valid); else pass_cnt++;
    total_cnt++; if (instr !== 11'h2A5) $display("FAIL nominal_instr: got %h expected 2a5", instr); else pass_cnt++;
    $display("nominal frame 2a5 -> instr=%h valid=%b", instr, instr_valid);
    repeat (HALF) @(negedge clk);
    confirm = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_parity_err();
    logic [FW-1:0] f;
    int first;
    int width;
    f = 11'h2A5;
    rearm();
    for (int i = FW - 1; i >= 0; i--) send_bit(f[i]);
    @(negedge clk);
    mbedCommand = 1'b0;
    confirm = 1'b1;
    first = 0;
    width = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        if (first == 0) first = i;
        width++;
      end
    end
    confirm = 1'b0;
    repeat (HALF) @(negedge clk);
    $display("parity error frame -> err at %0d width %0d valid=%b", first, width, instr_valid);
    total_cnt++; if (first != 5) $display("FAIL parity_err_cycle: got %0d expected 5", first); else pass_cnt++;
    total_cnt++; if (width != 1) $display("FAIL parity_err_width: got %0d expected 1", width); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL parity_valid: got %b expected 0", instr_valid); else pass_cnt++;
    total_cnt++; if (waiting !== 1'b1) $display("FAIL parity_waiting: got %b expected 1", waiting); else pass_cnt++;
    total_cnt++; if (instr !== 11'h2A5) $display("FAIL parity_instr_kept: got %h expected 2a5", instr); else pass_cnt++;
    send_frame(11'h15A, 1'b1);
    total_cnt++; if (instr !== 11'h15A) $display("FAIL parity_resend_instr: got %h expected 15a", instr); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL parity_resend_valid: got %b expected 1", instr_valid); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int first;
    int width;
    rearm();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    mbedCommand = 1'b1;
    confirm = 1'b1;
    first = 0;
    width = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (i == HALF) confirm = 1'b0;
      if (frame_err === 1'b1) begin
        if (first == 0) first = i;
        width++;
      end
    end
    $display("timeout after 4 bits -> err at %0d width %0d", first, width);
    // 3 clk sync/detect to the shift, then TO idle cycles.
    total_cnt++; if (first != TO + 3) $display("FAIL timeout_cycle: got %0d expected %0d", first, TO + 3); else pass_cnt++;
    total_cnt++; if (width != 1) $display("FAIL timeout_width: got %0d expected 1", width); else pass_cnt++;
    total_cnt++; if (waiting !== 1'b1) $display("FAIL timeout_waiting: got %b expected 1", waiting); else pass_cnt++;
    send_frame(11'h0F3, 1'b0);
    total_cnt++; if (instr !== 11'h0F3) $display("FAIL timeout_next_instr: got %h expected 0f3", instr); else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    rearm();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (waiting !== 1'b0) $display("FAIL enable_drop_waiting: got %b expected 0", waiting); else pass_cnt++;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (waiting !== 1'b1) $display("FAIL enable_back_waiting: got %b expected 1", waiting); else pass_cnt++;
    send_frame(11'h4C1, 1'b0);
    total_cnt++; if (instr !== 11'h4C1) $display("FAIL enable_instr: got %h expected 4c1", instr); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL enable_valid: got %b expected 1", instr_valid); else pass_cnt++;
  endtask

  task automatic test_clear_hold();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mbedCommand = ~mbedCommand;
      confirm = 1'b1;
      repeat (3) @(negedge clk);
      confirm = 1'b0;
      repeat (3) @(negedge clk);
    end
    $display("hold after 20 toggles -> instr=%h valid=%b", instr, instr_valid);
    total_cnt++; if (instr !== 11'h4C1) $display("FAIL hold_instr: got %h expected 4c1", instr); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL hold_valid: got %b expected 1", instr_valid); else pass_cnt++;
    // Time clear so the confirm rise is detected in the same cycle.
    @(negedge clk);
    mbedCommand = 1'b1;
    confirm = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    $display("clear with coincident rise -> instr=%h valid=%b waiting=%b", instr, instr_valid, waiting);
    total_cnt++; if (instr !== 11'h000) $display("FAIL clear_instr: got %h expected 000", instr); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL clear_valid: got %b expected 0", instr_valid); else pass_cnt++;
    total_cnt++; if (waiting !== 1'b1) $display("FAIL clear_waiting: got %b expected 1", waiting); else pass_cnt++;
    repeat (HALF) @(negedge clk);
    confirm = 1'b0;
    repeat (HALF) @(negedge clk);
    send_frame(11'h2A5, 1'b1);
    total_cnt++; if (instr !== 11'h2A5) $display("FAIL clear_resend_instr: got %h expected 2a5", instr); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [FW-1:0] f;
    f = 11'h5E7;
    rearm();
    for (int i = 0; i < 7; i++) send_bit(i[0]);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    $display("reset mid-frame -> instr=%h valid=%b waiting=%b err=%b", instr, instr_valid, waiting, frame_err);
    total_cnt++; if (instr !== 11'h000) $display("FAIL midreset_instr: got %h expected 000", instr); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL midreset_valid: got %b expected 0", instr_valid); else pass_cnt++;
    total_cnt++; if (waiting !== 1'b0) $display("FAIL midreset_waiting: got %b expected 0", waiting); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL midreset_err: got %b expected 0", frame_err); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (waiting !== 1'b1) $display("FAIL midreset_rearm_waiting: got %b expected 1", waiting); else pass_cnt++;
    // Narrow confirm glitch straddling one rising edge carries f[10].
    @(negedge clk);
    mbedCommand = f[FW-1];
    #8 confirm = 1'b1;
    @(posedge clk);
    #2 confirm = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = FW - 2; i >= 0; i--) send_bit(f[i]);
    send_bit(1'b0);
    repeat (5) @(negedge clk);
    $display("glitch + 11 bits -> instr=%h valid=%b", instr, instr_valid);
    total_cnt++; if (instr !== 11'h5E7) $display("FAIL glitch_instr: got %h expected 5e7", instr); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL glitch_valid: got %b expected 1", instr_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_parity_err();
    test_timeout();
    test_enable_drop();
    test_clear_hold();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
